arbitro_multiplicador: RTL and testbench

ARBITRO_MULTIPLICADOR -- requirements
Module: arbitro_multiplicador

---
 rtl/arbitro_multiplicador_pkg.sv | 20 ++
 rtl/arbitro_multiplicador_rom.sv | 13 +
 rtl/arbitro_multiplicador.sv | 96 +++++++++
 tb/tb_arbitro_multiplicador.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_multiplicador_pkg.sv
// Shared widths, FSM encodings and the product helper
// used by the two-requester multiplier arbiter.
package arbitro_multiplicador_pkg;

  localparam int FATOR_W   = 5;
  localparam int PRODUTO_W = 10;
  localparam int OPS_W     = 8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CONSULTA = 2'd1;
  localparam logic [1:0] RESPOSTA = 2'd2;

  function automatic logic [PRODUTO_W-1:0] mult(
    input logic [FATOR_W-1:0] a,
    input logic [FATOR_W-1:0] b
  );
    return PRODUTO_W'(a) * PRODUTO_W'(b);
  endfunction

endpackage

// File: rtl/arbitro_multiplicador_rom.sv
// Product lookup: Fatores = {a, b}, Produto = a*b.
// Purely combinational; the arbiter waits for it to settle.
module rom_multiplicador
  import arbitro_multiplicador_pkg::*;
(
  input  logic [2*FATOR_W-1:0] Fatores,
  output logic [PRODUTO_W-1:0] Produto
);

  assign Produto = mult(Fatores[2*FATOR_W-1:FATOR_W],
                        Fatores[FATOR_W-1:0]);

endmodule

// File: rtl/arbitro_multiplicador.sv
// Two-requester arbiter sharing one multiplier ROM.
// Round-robin on ties; one operation in flight at a time.
module arbitro_multiplicador
  import arbitro_multiplicador_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [FATOR_W-1:0]   req0_a,
  input  logic [FATOR_W-1:0]   req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [FATOR_W-1:0]   req1_a,
  input  logic [FATOR_W-1:0]   req1_b,
  output logic                 req1_ready,
  output logic                 resp_valid,
  output logic                 resp_id,
  output logic [PRODUTO_W-1:0] resp_produto,
  input  logic                 resp_ready,
  output logic [OPS_W-1:0]     ops_count
);

  logic [1:0]           state;
  logic [FATOR_W-1:0]   a_q;
  logic [FATOR_W-1:0]   b_q;
  logic                 id_q;
  logic                 last_id;
  logic [3:0]           cnt;
  logic [PRODUTO_W-1:0] produto;
  logic                 idle;
  logic                 g0;
  logic                 g1;
  logic                 take;

  assign idle = (state == IDLE);

  // last_id = 1 lets requester 0 win a tie, and vice versa
  assign g0 = req0_valid & (~req1_valid | last_id);
  assign g1 = req1_valid & (~req0_valid | ~last_id);

  assign req0_ready = rst_n & idle & g0;
  assign req1_ready = rst_n & idle & g1;
  assign take       = req0_ready | req1_ready;

  assign resp_valid = (state == RESPOSTA);

  rom_multiplicador u_rom (
    .Fatores ({a_q, b_q}),
    .Produto (produto)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_id      <= 1'b1;
      cnt          <= '0;
      resp_id      <= 1'b0;
      resp_produto <= '0;
      ops_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q     <= req1_ready ? req1_a : req0_a;
            b_q     <= req1_ready ? req1_b : req0_b;
            id_q    <= req1_ready;
            last_id <= req1_ready;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= CONSULTA;
          end
        end
        CONSULTA: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            resp_produto <= produto;
            resp_id      <= id_q;
            state        <= RESPOSTA;
          end
        end
        RESPOSTA: begin
          if (resp_ready) begin
            ops_count <= ops_count + OPS_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Random + directed bench for arbitro_multiplicador against
// a transaction-level timing/arbitration reference model.
module tb_arbitro_multiplicador;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [4:0] req0_a = '0;
  logic [4:0] req0_b = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [4:0] req1_a = '0;
  logic [4:0] req1_b = '0;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_id;
  logic [9:0] resp_produto;
  logic       resp_ready = 1'b0;
  logic [7:0] ops_count;

  always #5 clk = ~clk;

  arbitro_multiplicador #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_produto (resp_produto),
    .resp_ready   (resp_ready),
    .ops_count    (ops_count)
  );

  int checks = 0;
  int fails  = 0;

  bit armed = 0;
  bit busy  = 0;
  int last  = 1;
  int ops   = 0;
  int cyc   = 0;
  int due   = 0;
  int mid   = 0;
  int mprod = 0;
  int log_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check against model, then advance model
  task automatic step(input bit v0, input int a0, input int b0,
                      input bit v1, input int a1, input int b1,
                      input bit rr, input bit rn);
    int g;
    bit rv;
    @(negedge clk);
    req0_valid = v0;
    req0_a     = 5'(a0);
    req0_b     = 5'(b0);
    req1_valid = v1;
    req1_a     = 5'(a1);
    req1_b     = 5'(b1);
    resp_ready = rr;
    rst_n      = rn;
    #1;
    g = -1;
    if (rn && !busy) begin
      if (v0 && v1) g = (last == 0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    rv = busy && (cyc >= due);
    if (armed) begin
      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      chk("resp_valid", 32'(resp_valid), 32'(rv));
      if (rv) begin
        chk("resp_id", 32'(resp_id), 32'(mid));
        chk("resp_produto", 32'(resp_produto), 32'(mprod));
      end
      chk("ops_count", 32'(ops_count), 32'(ops));
    end
    @(posedge clk);
    if (!rn) begin
      busy  = 0;
      last  = 1;
      ops   = 0;
      armed = 1;
    end else if (g >= 0) begin
      busy  = 1;
      due   = cyc + 1 + W;
      mid   = g;
      mprod = (g == 1) ? (a1 & 31) * (b1 & 31) : (a0 & 31) * (b0 & 31);
      last  = g;
    end else if (rv && rr) begin
      busy = 0;
      ops  = (ops + 1) % 256;
      log_q.push_back(mid * 1024 + mprod);
    end
    cyc++;
  endtask

  task automatic do_reset();
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_produto", 32'(resp_produto), 0);
    chk("rst_ops_count", 32'(ops_count), 0);
    log_q.delete();
  endtask

  task automatic drain();
    repeat (W + 4) step(0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    // single requester 10x10
    do_reset();
    step(1, 10, 10, 0, 0, 0, 1, 1);
    drain();
    chk("t31_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("t31_r0", log_q[0], 100);

    // tie from reset: req0 first
    do_reset();
    repeat (2 * (W + 2)) step(1, 27, 19, 1, 15, 19, 1, 1);
    drain();
    chk("t32_n", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t32_r0", log_q[0], 513);
      chk("t32_r1", log_q[1], 1024 + 285);
    end

    // alternation under sustained contention
    do_reset();
    repeat (4 * (W + 2)) step(1, 10, 0, 1, 9, 22, 1, 1);
    drain();
    chk("t33_n", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("t33_r0", log_q[0], 0);
      chk("t33_r1", log_q[1], 1024 + 198);
      chk("t33_r2", log_q[2], 0);
      chk("t33_r3", log_q[3], 1024 + 198);
    end

    // back-pressure with both requesters pending
    do_reset();
    step(1, 31, 31, 0, 0, 0, 0, 1);
    repeat (W + 5) step(1, 2, 3, 1, 4, 5, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    drain();
    chk("t34_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("t34_r0", log_q[0], 961);

    // reset in flight discards the operation
    do_reset();
    step(0, 0, 0, 1, 13, 7, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    drain();
    chk("t35_none", log_q.size(), 0);
    step(1, 3, 4, 1, 5, 6, 1, 1);
    drain();
    chk("t35_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("t35_tie", log_q[0], 12);

    // 256 back-to-back operations wrap the counter
    do_reset();
    repeat (256 * (W + 2))
      step(1, $urandom_range(0, 31), $urandom_range(0, 31),
           1, $urandom_range(0, 31), $urandom_range(0, 31), 1, 1);
    drain();
    chk("t36_n", log_q.size(), 256);
    #1;
    chk("t36_wrap", 32'(ops_count), 0);

    // free-running random traffic
    do_reset();
    repeat (2000)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 60) != 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
